// File: rtl/bitstream_decoder.sv
// Bipolar stochastic bitstream decoder: sums in_p - in_m over 2^WINDOW_LOG2
// valid samples and hands the signed count out over a valid/ready port.
module bitstream_decoder #(
  parameter  int WINDOW_LOG2 = 8,
  localparam int ACC_WIDTH   = WINDOW_LOG2 + 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic                        in_p,
  input  logic                        in_m,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_value
);

  localparam int CW = WINDOW_LOG2 + 1;
  localparam logic [CW-1:0] N_CNT = {1'b1, {WINDOW_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t                      state_q;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] step;
  logic        [CW-1:0]        cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] out_value_q;
  logic                        busy_q;
  logic                        out_valid_q;

  // in_p=in_m=1 cancels to zero, as does 0/0
  always_comb begin
    step = '0;
    if (in_p && !in_m) begin
      step = ACC_WIDTH'(1);
    end else if (!in_p && in_m) begin
      step = -ACC_WIDTH'(1);
    end
    acc_d = acc_q + step;
    cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_value_q <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (cnt_d == N_CNT) begin
              state_q     <= DONE;
              out_value_q <= acc_d;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (start) begin
              state_q <= ACCUM;
              acc_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;

endmodule
